remote_cmd_sched: RTL and testbench
===================================

Name: remote_cmd_sched

Overview:
Sequencer that owns the 16-bit command link into the Knight (RemoteComm send_cmd/cmd_sent/resp_rdy/resp interface). It buffers a queue of host commands (CAL, MOV, tour) and issues them one at a time. Each command must be acknowledged with 8'hA5 before the next is issued. It reports completion, timeout and bad-acknowledge errors, and sits between a command source (bench script or host FSM) and RemoteComm.

Parameters:
DEPTH, 8, command queue entries (power of 2, at least 2)
TIMEOUT, 4000000, clock cycles allowed per wait phase (a MOV needs more than 3M cycles); benches use 1000
ACK, 8'hA5, response value meaning success

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
push  in  1  enqueue push_cmd this cycle
push_cmd  in  16  command to enqueue
full  out  1  queue holds DEPTH entries
empty  out  1  queue holds 0 entries
start  in  1  begin draining queue (ignored unless IDLE)
abort  in  1  flush and return to IDLE
send_cmd  out  1  one-cycle pulse to RemoteComm
cmd  out  16  command presented to RemoteComm, held stable
cmd_sent  in  1  RemoteComm finished transmitting
resp_rdy  in  1  response byte valid (pulse)
resp  in  8  response byte
busy  out  1  state is not IDLE
done  out  1  one-cycle pulse: queue drained with all ACKs
err  out  1  sticky error flag
err_code  out  2  0 none, 1 TX timeout, 2 RESP timeout, 3 bad response
ovf  out  1  sticky: push attempted while full
n_acked  out  $clog2(DEPTH+1)  commands acknowledged since last start

Behaviour:
- Reset (rst sampled high at posedge): state IDLE, queue empty. All outputs 0 except empty=1 (cmd=0, send_cmd=0, done=0, err=0, err_code=0, ovf=0, n_acked=0). Reset mid-transaction aborts with no done pulse.
- Queue: FIFO with wrapping pointers.
  - push while full: entry dropped, ovf set.
  - push and pop in the same cycle while full: legal, entry accepted.
  - push is accepted in every state, including while draining.
- FSM states: IDLE, LOAD, SEND, WAIT_SENT, WAIT_RESP, DONE, ERR.
- IDLE:
  - start with empty=0: clear err, err_code and n_acked, then go to LOAD.
  - start with empty=1: done pulses next cycle; state stays IDLE.
- LOAD: pop head into cmd register, then go to SEND. cmd holds until the next LOAD.
- SEND: send_cmd=1 for exactly this cycle; timer cleared; go to WAIT_SENT.
- WAIT_SENT:
  - cmd_sent: go to WAIT_RESP, timer cleared.
  - Otherwise, when timer reaches TIMEOUT-1: go to ERR with code 1.
  - resp_rdy is ignored in this state.
- WAIT_RESP (resp sampled only when resp_rdy=1):
  - resp==ACK: n_acked increments; go to LOAD if queue non-empty, else DONE.
  - resp!=ACK: go to ERR with code 3.
  - No resp_rdy by timer TIMEOUT-1: go to ERR with code 2.
  - A command pushed in the same cycle as the final ACK is seen as non-empty and is issued.
- DONE: done=1 for one cycle; go to IDLE.
- ERR: err set and err_code latched; queue flushed; go to IDLE next cycle. err stays high until the next accepted start or rst.
- abort in any non-IDLE state: flush queue and go to IDLE. No done pulse, err unchanged. abort has priority over all other transitions in that cycle. If send_cmd would fire in the same cycle, it is suppressed.
- Timer: width $clog2(TIMEOUT). Counts only in WAIT_SENT and WAIT_RESP; saturates, never wraps.
- Latency, start to first send_cmd: 2 cycles (IDLE, then LOAD, then SEND).

Decomposition:
- Package knight_cmd_pkg holds:
  - state enum sched_state_t
  - err_code_t enum: ERR_NONE, ERR_TX_TO, ERR_RESP_TO, ERR_BAD_RESP
  - POS_ACK = 8'hA5
  - command opcode constants (CAL_CMD, MOV_EAST, ...) shared with the bench tasks
- One sub-module: cmd_fifo (parameterised DEPTH x 16, push/pop/full/empty/flush, same clk/rst).

Test Plan:
1. TIMEOUT=1000. Push CAL_CMD, then MOV_EAST|1, then start; model answers A5 to each -> two send_cmd pulses with cmd matching in order, n_acked=2, one done pulse, err=0.
2. Push one command, start, model returns 8'h5A -> err=1, err_code=3, queue empty, busy=0, no done.
3. Push one command, start, never assert cmd_sent -> ERR 1000 cycles after SEND, err_code=1. Repeat with cmd_sent but no resp -> err_code=2.
4. Push 9 commands with DEPTH=8 -> full=1 after 8, ovf=1. Drain with A5 on each -> exactly 8 issued, n_acked=8.
5. Start a 3-command run and assert abort during the second WAIT_RESP -> IDLE next cycle, empty=1, no further send_cmd, no done. A late resp_rdy afterwards is ignored.
6. start with empty queue -> done pulses 1 cycle later, send_cmd never asserted. rst mid-WAIT_RESP -> all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/knight_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : knight_cmd_pkg
// Description : Shared types and constants for the Knight command link.
//               Holds the scheduler state and error-code enums, the positive
//               acknowledge byte, and the opcode words used by command
//               sources.
// Revision    : 1.0 - initial release
// ============================================================================
package knight_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_SEND      = 3'd2,
        ST_WAIT_SENT = 3'd3,
        ST_WAIT_RESP = 3'd4,
        ST_DONE      = 3'd5,
        ST_ERR       = 3'd6
    } sched_state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_TX_TO    = 2'd1,
        ERR_RESP_TO  = 2'd2,
        ERR_BAD_RESP = 2'd3
    } err_code_t;

    localparam logic [7:0] POS_ACK = 8'hA5;

    // Opcode in [15:12]; for moves, heading in [11:4] and square count in [3:0].
    localparam logic [15:0] CAL_CMD   = 16'h2000;
    localparam logic [15:0] MOV_NORTH = 16'h4000;
    localparam logic [15:0] MOV_WEST  = 16'h43F0;
    localparam logic [15:0] MOV_SOUTH = 16'h47F0;
    localparam logic [15:0] MOV_EAST  = 16'h4BF0;
    localparam logic [15:0] TOUR_CMD  = 16'h6000;

endpackage : knight_cmd_pkg
`default_nettype wire

// File: rtl/cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cmd_fifo
// Description : DEPTH x WIDTH first-in first-out buffer with wrapping
//               pointers and a synchronous flush. A push while full is
//               accepted only when a pop frees a slot in the same cycle.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_push/i_push_data - write request and data
//               i_pop           - remove the head entry (ignored when empty)
//               i_flush         - discard all entries
//               o_head          - current head entry
//               o_full/o_empty  - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == c_CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_head    = r_mem[r_rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + c_CW'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - c_CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

endmodule : cmd_fifo
`default_nettype wire

// File: rtl/remote_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module      : remote_cmd_sched
// Description : Queues 16-bit host commands and issues them one at a time
//               over the RemoteComm link, requiring an ACK byte for each
//               before the next is sent. Reports completion, TX/response
//               timeouts and bad acknowledges.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               push, push_cmd      - enqueue a command
//               full, empty, ovf    - queue status, sticky overflow
//               start, abort        - run control
//               send_cmd, cmd       - command strobe and held command word
//               cmd_sent, resp_rdy, resp - RemoteComm status and reply byte
//               busy, done, err, err_code, n_acked - run status
// Revision    : 1.0 - initial release
// ============================================================================
module remote_cmd_sched
    import knight_cmd_pkg::*;
#(
    parameter int         DEPTH   = 8,
    parameter int         TIMEOUT = 4000000,
    parameter logic [7:0] ACK     = POS_ACK
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [15:0]                push_cmd,
    output logic                       full,
    output logic                       empty,
    input  logic                       start,
    input  logic                       abort,
    output logic                       send_cmd,
    output logic [15:0]                cmd,
    input  logic                       cmd_sent,
    input  logic                       resp_rdy,
    input  logic [7:0]                 resp,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [1:0]                 err_code,
    output logic                       ovf,
    output logic [$clog2(DEPTH+1)-1:0] n_acked
);

    localparam int                     c_TIMER_W   = $clog2(TIMEOUT);
    localparam logic [c_TIMER_W-1:0]   c_TIMER_LAST = c_TIMER_W'(TIMEOUT - 1);
    localparam int                     c_CNT_W     = $clog2(DEPTH + 1);

    sched_state_t         r_state;
    sched_state_t         w_next_state;
    err_code_t            w_err_cause;
    err_code_t            r_err_code;
    logic [c_TIMER_W-1:0] r_timer;
    logic [15:0]          r_cmd;
    logic [15:0]          w_head;
    logic [c_CNT_W-1:0]   r_n_acked;
    logic                 r_err;
    logic                 r_ovf;
    logic                 r_done_empty;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic                 w_pop;
    logic                 w_flush;
    logic                 w_timeout;
    logic                 w_start_run;
    logic                 w_start_empty;
    logic                 w_ack;

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (push),
        .i_push_data (push_cmd),
        .i_pop       (w_pop),
        .i_flush     (w_flush),
        .o_head      (w_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    assign w_timeout     = (r_timer == c_TIMER_LAST);
    assign w_start_run   = (r_state == ST_IDLE) && start && !w_fifo_empty;
    assign w_start_empty = (r_state == ST_IDLE) && start && w_fifo_empty;
    assign w_ack         = (r_state == ST_WAIT_RESP) && resp_rdy && (resp == ACK) && !abort;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        w_err_cause  = ERR_NONE;
        unique case (r_state)
            ST_IDLE: begin
                if (start && !w_fifo_empty) begin
                    w_next_state = ST_LOAD;
                end
            end
            ST_LOAD:  w_next_state = ST_SEND;
            ST_SEND:  w_next_state = ST_WAIT_SENT;
            ST_WAIT_SENT: begin
                if (cmd_sent) begin
                    w_next_state = ST_WAIT_RESP;
                end else if (w_timeout) begin
                    w_next_state = ST_ERR;
                    w_err_cause  = ERR_TX_TO;
                end
            end
            ST_WAIT_RESP: begin
                if (resp_rdy) begin
                    if (resp == ACK) begin
                        // A push landing on the final ACK cycle still counts
                        // as pending work; an empty queue always accepts it.
                        w_next_state = (!w_fifo_empty || push) ? ST_LOAD : ST_DONE;
                    end else begin
                        w_next_state = ST_ERR;
                        w_err_cause  = ERR_BAD_RESP;
                    end
                end else if (w_timeout) begin
                    w_next_state = ST_ERR;
                    w_err_cause  = ERR_RESP_TO;
                end
            end
            ST_DONE:  w_next_state = ST_IDLE;
            ST_ERR:   w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
        if (abort && (r_state != ST_IDLE)) begin
            w_next_state = ST_IDLE;
        end
    end

    // Output logic
    always_comb begin
        send_cmd = 1'b0;
        w_pop    = 1'b0;
        w_flush  = 1'b0;
        done     = r_done_empty;
        busy     = (r_state != ST_IDLE);
        unique case (r_state)
            ST_LOAD: w_pop    = !abort;
            ST_SEND: send_cmd = !abort;
            ST_DONE: done     = !abort;
            ST_ERR:  w_flush  = 1'b1;
            default: ;
        endcase
        if (abort && (r_state != ST_IDLE)) begin
            w_flush = 1'b1;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done_empty <= 1'b0;
            r_cmd        <= '0;
            r_timer      <= '0;
            r_err        <= 1'b0;
            r_err_code   <= ERR_NONE;
            r_n_acked    <= '0;
            r_ovf        <= 1'b0;
        end else begin
            // Start on an empty queue completes trivially one cycle later.
            r_done_empty <= w_start_empty;

            if (w_pop) begin
                r_cmd <= w_head;
            end

            // Runs only while waiting on RemoteComm; cleared on every other
            // cycle, including SEND and the WAIT_SENT -> WAIT_RESP handoff.
            if ((r_state == ST_WAIT_SENT && !cmd_sent) || (r_state == ST_WAIT_RESP)) begin
                if (r_timer != '1) begin
                    r_timer <= r_timer + c_TIMER_W'(1);
                end
            end else begin
                r_timer <= '0;
            end

            if (w_start_run) begin
                r_err      <= 1'b0;
                r_err_code <= ERR_NONE;
                r_n_acked  <= '0;
            end else begin
                if (w_next_state == ST_ERR) begin
                    r_err      <= 1'b1;
                    r_err_code <= w_err_cause;
                end
                if (w_ack) begin
                    r_n_acked <= r_n_acked + c_CNT_W'(1);
                end
            end

            if (push && w_fifo_full && !w_pop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign cmd      = r_cmd;
    assign err      = r_err;
    assign err_code = r_err_code;
    assign ovf      = r_ovf;
    assign n_acked  = r_n_acked;
    assign full     = w_fifo_full;
    assign empty    = w_fifo_empty;

endmodule : remote_cmd_sched
`default_nettype wire

// File: tb/tb_remote_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_remote_cmd_sched
// Description : Self-checking bench for remote_cmd_sched. A queue of the
//               commands that should go out, in order, is kept as the
//               reference; a RemoteComm stand-in answers each send_cmd with
//               randomly delayed cmd_sent / resp_rdy handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_remote_cmd_sched;
    import knight_cmd_pkg::*;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        push;
    logic [15:0] push_cmd;
    logic        full;
    logic        empty;
    logic        start;
    logic        abort;
    logic        send_cmd;
    logic [15:0] cmd;
    logic        cmd_sent;
    logic        resp_rdy;
    logic [7:0]  resp;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
    logic        ovf;
    logic [3:0]  n_acked;

    remote_cmd_sched #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT),
        .ACK     (POS_ACK)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_cmd (push_cmd),
        .full     (full),
        .empty    (empty),
        .start    (start),
        .abort    (abort),
        .send_cmd (send_cmd),
        .cmd      (cmd),
        .cmd_sent (cmd_sent),
        .resp_rdy (resp_rdy),
        .resp     (resp),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_code (err_code),
        .ovf      (ovf),
        .n_acked  (n_acked)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Link observer: logs every issued command word and counts done pulses.
    int          n_send = 0;
    int          n_done = 0;
    logic [15:0] sent_log [1024];

    always @(posedge clk) begin
        if (send_cmd) begin
            if (n_send < 1024) sent_log[n_send] <= cmd;
            n_send <= n_send + 1;
        end
        if (done) n_done <= n_done + 1;
    end

    logic [15:0] exp_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [15:0] rand_cmd();
        logic [15:0] base;
        case ($urandom_range(0, 5))
            0:       base = CAL_CMD;
            1:       base = MOV_NORTH;
            2:       base = MOV_WEST;
            3:       base = MOV_SOUTH;
            4:       base = MOV_EAST;
            default: base = TOUR_CMD;
        endcase
        return base | 16'($urandom_range(1, 7));
    endfunction

    task automatic do_push(input logic [15:0] c);
        push = 1'b1; push_cmd = c;
        tick();
        push = 1'b0;
    endtask

    // start, then the first send_cmd must be visible exactly two cycles on.
    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check_eq("start_latency", 32'(send_cmd), 32'd1);
    endtask

    task automatic wait_send(input int idx);
        for (int k = 0; k < 50 && n_send <= idx; k++) tick();
        check_eq("send_seen", 32'(n_send > idx), 32'd1);
    endtask

    task automatic give_sent();
        repeat ($urandom_range(0, 3)) tick();
        cmd_sent = 1'b1;
        tick();
        cmd_sent = 1'b0;
    endtask

    task automatic give_resp(input logic [7:0] rv, input bit with_push, input logic [15:0] c);
        repeat ($urandom_range(0, 3)) tick();
        resp_rdy = 1'b1; resp = rv;
        if (with_push) begin push = 1'b1; push_cmd = c; end
        tick();
        resp_rdy = 1'b0; push = 1'b0; resp = 8'($urandom);
    endtask

    // mode 0: plain; 1: push c while the command is in flight; 2: push c on the ACK cycle
    task automatic serve_one(input int idx, input logic [7:0] rv, input int mode, input logic [15:0] c);
        wait_send(idx);
        if (mode == 1) do_push(c);
        give_sent();
        give_resp(rv, mode == 2, c);
    endtask

    task automatic check_order(input int bs);
        check_eq("send_count", 32'(n_send - bs), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            check_eq("cmd_order", 32'(sent_log[bs + i]), 32'(exp_q[i]));
    endtask

    task automatic check_reset_outs(input string tag);
        check_eq(tag, 32'({full, empty, busy, send_cmd, done, err, err_code, ovf, n_acked, cmd}),
                 32'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'd0, 16'd0}));
    endtask

    initial begin
        int          bs;
        int          bd;
        int          cnt;
        int          mode;
        int          n;
        bit          late_used;
        logic [15:0] c;
        logic [7:0]  bv;

        rst = 1'b1; push = 1'b0; push_cmd = '0; start = 1'b0; abort = 1'b0;
        cmd_sent = 1'b0; resp_rdy = 1'b0; resp = '0;
        repeat (3) tick();
        check_reset_outs("reset_outs");
        rst = 1'b0;
        tick();

        // Randomized ACK-everything runs, with pushes while draining.
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(1, DEPTH - 2);
            bs = n_send; bd = n_done; late_used = 1'b0;
            exp_q.delete();
            for (int i = 0; i < n; i++) begin
                c = rand_cmd(); exp_q.push_back(c); do_push(c);
            end
            do_start();
            for (int i = 0; i < exp_q.size(); i++) begin
                mode = 0; c = '0;
                if (i == 0 && r[0]) begin
                    c = rand_cmd(); exp_q.push_back(c); mode = 1;
                end else if (r == 2 && !late_used && i == exp_q.size() - 1) begin
                    c = rand_cmd(); exp_q.push_back(c); mode = 2; late_used = 1'b1;
                end
                serve_one(bs + i, POS_ACK, mode, c);
            end
            repeat (3) tick();
            check_order(bs);
            check_eq("run_done", 32'(n_done - bd), 32'd1);
            check_eq("run_n_acked", 32'(n_acked), 32'(exp_q.size()));
            check_eq("run_err", 32'(err), 32'd0);
            check_eq("run_idle", 32'({busy, empty}), 32'b01);
        end

        // Bad acknowledge on the second of three commands.
        bs = n_send; bd = n_done;
        for (int i = 0; i < 3; i++) do_push(rand_cmd());
        do_start();
        serve_one(bs, POS_ACK, 0, '0);
        bv = 8'($urandom_range(0, 255));
        if (bv == POS_ACK) bv = 8'h5A;
        serve_one(bs + 1, bv, 0, '0);
        check_eq("bad_err", 32'({err, err_code}), 32'({1'b1, ERR_BAD_RESP}));
        tick();
        check_eq("bad_idle", 32'({busy, empty}), 32'b01);
        repeat (5) tick();
        check_eq("bad_sends", 32'(n_send - bs), 32'd2);
        check_eq("bad_no_done", 32'(n_done - bd), 32'd0);
        check_eq("bad_n_acked", 32'(n_acked), 32'd1);

        // TX timeout; a stray resp_rdy while waiting for cmd_sent is ignored.
        do_push(rand_cmd());
        do_start();
        cnt = 0;
        for (int k = 0; k < TIMEOUT + 100 && !err; k++) begin
            resp_rdy = (k == 10); resp = POS_ACK;
            tick();
            cnt++;
        end
        resp_rdy = 1'b0;
        check_eq("tx_to_cycles", 32'(cnt), 32'(TIMEOUT + 1));
        check_eq("tx_to_code", 32'(err_code), 32'(ERR_TX_TO));
        tick();
        check_eq("tx_to_idle", 32'({busy, empty}), 32'b01);

        // Response timeout.
        do_push(rand_cmd());
        do_start();
        tick();
        cmd_sent = 1'b1;
        tick();
        cmd_sent = 1'b0;
        cnt = 0;
        for (int k = 0; k < TIMEOUT + 100 && !err; k++) begin
            tick();
            cnt++;
        end
        check_eq("resp_to_cycles", 32'(cnt), 32'(TIMEOUT));
        check_eq("resp_to_code", 32'(err_code), 32'(ERR_RESP_TO));

        // Overflow: nine pushes into eight slots, then drain.
        repeat (2) tick();
        bs = n_send; bd = n_done;
        exp_q.delete();
        for (int i = 0; i < DEPTH + 1; i++) begin
            c = rand_cmd();
            if (i < DEPTH) exp_q.push_back(c);
            do_push(c);
            if (i == DEPTH - 1) check_eq("full_at_depth", 32'({full, ovf}), 32'b10);
        end
        check_eq("ovf_set", 32'({full, ovf}), 32'b11);
        do_start();
        for (int i = 0; i < DEPTH; i++) serve_one(bs + i, POS_ACK, 0, '0);
        repeat (3) tick();
        check_order(bs);
        check_eq("ovf_n_acked", 32'(n_acked), 32'(DEPTH));
        check_eq("ovf_done", 32'(n_done - bd), 32'd1);
        check_eq("ovf_err_cleared", 32'(err), 32'd0);

        // Abort during the second WAIT_RESP; a late reply is ignored.
        bs = n_send; bd = n_done;
        for (int i = 0; i < 3; i++) do_push(rand_cmd());
        do_start();
        serve_one(bs, POS_ACK, 0, '0);
        wait_send(bs + 1);
        give_sent();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("abort_idle", 32'({busy, empty}), 32'b01);
        repeat (5) tick();
        resp_rdy = 1'b1; resp = POS_ACK;
        tick();
        resp_rdy = 1'b0;
        repeat (20) tick();
        check_eq("abort_sends", 32'(n_send - bs), 32'd2);
        check_eq("abort_no_done", 32'(n_done - bd), 32'd0);
        check_eq("abort_n_acked", 32'({busy, err, n_acked}), 32'({1'b0, 1'b0, 4'd1}));

        // Abort in SEND suppresses the strobe.
        bs = n_send;
        do_push(rand_cmd());
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (3) tick();
        check_eq("abort_send_supp", 32'(n_send - bs), 32'd0);
        check_eq("abort_send_idle", 32'({busy, empty}), 32'b01);

        // Start on an empty queue.
        bs = n_send; bd = n_done;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("empty_start_done", 32'({done, busy}), 32'b10);
        tick();
        check_eq("empty_start_pulse", 32'(done), 32'd0);
        repeat (3) tick();
        check_eq("empty_start_sends", 32'(n_send - bs), 32'd0);
        check_eq("empty_start_dcnt", 32'(n_done - bd), 32'd1);

        // Reset in the middle of the second WAIT_RESP.
        bd = n_done;
        bs = n_send;
        for (int i = 0; i < 2; i++) do_push(rand_cmd());
        do_start();
        serve_one(bs, POS_ACK, 0, '0);
        wait_send(bs + 1);
        give_sent();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outs("rst_mid_outs");
        repeat (5) tick();
        check_eq("rst_mid_no_done", 32'(n_done - bd), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_remote_cmd_sched
`default_nettype wire
